struct_deser: RTL and testbench

STRUCT_DESER -- requirements
Module: struct_deser

---
 rtl/struct_pkg.sv | 21 ++
 rtl/struct_deser.sv | 113 +++++++++++
 tb/tb_struct_deser.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/struct_pkg.sv
// Shared types for the serial-to-struct deserializer: word layout, widths and FSM states.
package struct_pkg;

   localparam int unsigned WORD_W = 5;
   localparam int unsigned A_W    = 2;
   localparam int unsigned B_W    = 3;
   localparam int unsigned CNT_W  = 3;

   typedef struct packed {
      logic [A_W-1:0] a;
      logic [B_W-1:0] b;
   } struct_1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/struct_deser.sv
// Collects a 5-bit struct_1 word from a serial valid/ready stream (MSB first, s_last framed)
// and presents it on a valid/ready output; frames of the wrong length raise a one-cycle err.
module struct_deser
   import struct_pkg::*;
#(
   parameter struct_1 RST_VAL = '{a: '1, b: '0}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic [A_W-1:0]    m_a,
   output logic [B_W-1:0]    m_b,
   output logic              err
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WORD_W-1:0]  shreg_q, shreg_d;
   struct_1            m_data_q, m_data_d;
   logic               m_valid_q, m_valid_d;
   logic               err_q, err_d;
   logic               xfer;
   logic               fifth_bit;
   logic [WORD_W-1:0]  shift_in;

   // Ready is withheld only while a word waits downstream, and throughout reset.
   assign s_ready   = ~rst & (state_q != FULL);
   assign xfer      = s_valid & s_ready;
   assign fifth_bit = (cnt_q == CNT_W'(WORD_W - 1));
   assign shift_in  = {shreg_q[WORD_W-2:0], s_data};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      m_data_d = m_data_q;
      err_d    = 1'b0;

      case (state_q)
         IDLE, SHIFT: begin
            if (xfer) begin
               if (s_last) begin
                  cnt_d   = '0;
                  shreg_d = '0;
                  if (fifth_bit) begin
                     m_data_d = struct_1'(shift_in);
                     state_d  = FULL;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end else if (fifth_bit) begin
                  // Frame overran the word: flag once, then swallow the rest.
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  shreg_d = '0;
                  state_d = DRAIN;
               end else begin
                  shreg_d = shift_in;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = SHIFT;
               end
            end
         end
         FULL: begin
            if (m_ready) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (xfer && s_last) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      m_valid_d = (state_d == FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shreg_q   <= '0;
         m_data_q  <= RST_VAL;
         m_valid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         err_q     <= err_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_a     = m_data_q.a;
   assign m_b     = m_data_q.b;
   assign err     = err_q;

endmodule

// File: tb/tb_struct_deser.sv
// Directed bench for struct_deser: good, backpressured, short, long, reset-interrupted and gapped frames.
module tb_struct_deser;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_valid;
   logic       s_ready;
   logic       s_data;
   logic       s_last;
   logic       m_valid;
   logic       m_ready;
   logic [4:0] m_data;
   logic [1:0] m_a;
   logic [2:0] m_b;
   logic       err;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;

   struct_deser dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_a     (m_a),
      .m_b     (m_b),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Running count of err pulses seen at clock edges.
   always @(posedge clk) begin
      if (err === 1'b1) err_cnt <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one bit and hold it until accepted (bounded wait).
   task automatic send_bit(input logic d, input logic last);
      int waited;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      waited  = 0;
      while (s_ready !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      if (waited >= 20) begin
         checks++;
         errors++;
         $error("FAIL send_bit_timeout observed=%0d expected=%0d", waited, 0);
      end
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 1'b0;
   endtask

   task automatic send_frame(input logic [4:0] w);
      for (int i = 4; i >= 0; i--) send_bit(w[i], (i == 0));
   endtask

   task automatic handshake();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = 1'b0; s_last = 1'b0; m_ready = 1'b0;
      step();
      step();
      check("rst_s_ready", 8'(s_ready), 8'h0);
      check("rst_m_valid", 8'(m_valid), 8'h0);
      check("rst_m_data", 8'(m_data), 8'h18);
      check("rst_err", 8'(err), 8'h0);
      rst = 1'b0;
      #1;
      check("idle_s_ready", 8'(s_ready), 8'h1);

      // Good frame 1,1,0,0,0
      send_frame(5'b11000);
      check("good_m_valid", 8'(m_valid), 8'h1);
      check("good_m_data", 8'(m_data), 8'h18);
      check("good_m_a", 8'(m_a), 8'h3);
      check("good_m_b", 8'(m_b), 8'h0);
      check("good_s_ready", 8'(s_ready), 8'h0);

      // Backpressure
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_m_valid", 8'(m_valid), 8'h1);
         check("bp_m_data", 8'(m_data), 8'h18);
         check("bp_s_ready", 8'(s_ready), 8'h0);
      end
      handshake();
      check("hs_m_valid", 8'(m_valid), 8'h0);
      check("hs_s_ready", 8'(s_ready), 8'h1);
      check("hs_m_data_kept", 8'(m_data), 8'h18);
      check("good_err_cnt", 8'(err_cnt), 8'h0);

      // Short frame: s_last on the 3rd bit
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      check("short_err", 8'(err), 8'h1);
      check("short_m_valid", 8'(m_valid), 8'h0);
      step();
      check("short_err_pulse", 8'(err), 8'h0);
      check("short_m_data", 8'(m_data), 8'h18);
      check("short_err_cnt", 8'(err_cnt), 8'h1);
      send_frame(5'b01110);
      check("after_short_m_valid", 8'(m_valid), 8'h1);
      check("after_short_m_a", 8'(m_a), 8'h1);
      check("after_short_m_b", 8'(m_b), 8'h6);
      handshake();

      // Long frame: 7 bits, err on the 5th only
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      check("long_pre_err", 8'(err), 8'h0);
      send_bit(1'b1, 1'b0);
      check("long_err5", 8'(err), 8'h1);
      send_bit(1'b0, 1'b0);
      check("long_err6", 8'(err), 8'h0);
      check("long_drain_ready", 8'(s_ready), 8'h1);
      send_bit(1'b1, 1'b1);
      check("long_err7", 8'(err), 8'h0);
      check("long_m_valid", 8'(m_valid), 8'h0);
      check("long_m_data", 8'(m_data), 8'h0e);
      step();
      check("long_err_cnt", 8'(err_cnt), 8'h2);
      send_frame(5'b10101);
      check("after_long_m_valid", 8'(m_valid), 8'h1);
      check("after_long_m_data", 8'(m_data), 8'h15);
      handshake();

      // Reset mid-frame
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      rst = 1'b1;
      step();
      check("midrst_m_data", 8'(m_data), 8'h18);
      check("midrst_m_valid", 8'(m_valid), 8'h0);
      check("midrst_s_ready", 8'(s_ready), 8'h0);
      check("midrst_err", 8'(err), 8'h0);
      rst = 1'b0;
      #1;
      send_frame(5'b00111);
      check("after_rst_m_a", 8'(m_a), 8'h0);
      check("after_rst_m_b", 8'(m_b), 8'h7);
      check("after_rst_m_valid", 8'(m_valid), 8'h1);
      handshake();

      // Gapped frame 1,0,<gap 4>,1,1,0
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         s_data = 1'b1;
         s_last = 1'b1;
         step();
      end
      s_last = 1'b0;
      check("gap_no_err", 8'(err), 8'h0);
      check("gap_no_valid", 8'(m_valid), 8'h0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      check("gap_m_valid", 8'(m_valid), 8'h1);
      check("gap_m_data", 8'(m_data), 8'h16);
      handshake();
      step();
      check("final_err_cnt", 8'(err_cnt), 8'h2);
      check("final_m_data", 8'(m_data), 8'h16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
